// File: rtl/memc_pkg.sv
// Shared types and constants for the cartridge SRAM/PSRAM memory responder.
// The optional read tag is enabled by defining MEMC_RDCACHE_EN.
package memc_pkg;

  localparam int MEMC_AW = 23;
  localparam int MEMC_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_REC   = 3'd4
  } memc_state_e;

  typedef struct packed {
    logic [MEMC_AW-1:0] addr;
    logic [MEMC_DW-1:0] data;
    logic               be_lo;
    logic               be_hi;
    logic               valid;
  } memc_slot_t;

  // Wait-state counters count down from T-1 to 0.
  function automatic logic [3:0] wait_load(input int t);
    return 4'(t - 1);
  endfunction

endpackage

// File: rtl/memc_req.sv
// Request capture: registers the mapper strobes, detects read/write triggers
// and keeps one pending read slot and one pending write slot (write first).
module memc_req
  import memc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [MEMC_AW-1:0] mem_addr,
  input  logic [MEMC_DW-1:0] mem_dati,
  input  logic               mem_oe,
  input  logic               mem_we_lo,
  input  logic               mem_we_hi,
  input  logic               rd_hit,
  input  logic               take,
  output logic               wr_trig,
  output memc_slot_t         req,
  output logic               req_wr
);

  logic               oe_prev_r;
  logic               we_prev_r;
  logic [MEMC_AW-1:0] addr_prev_r;
  memc_slot_t         rd_slot_r;
  memc_slot_t         wr_slot_r;
  logic               rd_trig_s;

  // Trigger detection and write-first request selection
  always_comb begin
    rd_trig_s = mem_oe && (!oe_prev_r || (mem_addr != addr_prev_r));
    wr_trig   = (mem_we_lo || mem_we_hi) && !we_prev_r;
    req_wr    = wr_slot_r.valid;
    if (wr_slot_r.valid) begin
      req = wr_slot_r;
    end else begin
      req = rd_slot_r;
    end
  end

  // Input history and slots; a fresh trigger wins over the clear from take
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_prev_r   <= 1'b0;
      we_prev_r   <= 1'b0;
      addr_prev_r <= '0;
      rd_slot_r   <= '0;
      wr_slot_r   <= '0;
    end else begin
      oe_prev_r   <= mem_oe;
      we_prev_r   <= mem_we_lo || mem_we_hi;
      addr_prev_r <= mem_addr;

      if (wr_trig) begin
        wr_slot_r <= '{addr: mem_addr, data: mem_dati, be_lo: mem_we_lo,
                       be_hi: mem_we_hi, valid: 1'b1};
      end else if (take && req_wr) begin
        wr_slot_r.valid <= 1'b0;
      end

      // A tag hit satisfies the read on the spot, superseding an older pending read
      if (rd_trig_s && !rd_hit) begin
        rd_slot_r <= '{addr: mem_addr, data: '0, be_lo: 1'b0, be_hi: 1'b0, valid: 1'b1};
      end else if (rd_trig_s || (take && !req_wr)) begin
        rd_slot_r.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/memc_sram.sv
// Timed access sequencer for an external 16-bit asynchronous SRAM/PSRAM.
// Define MEMC_RDCACHE_EN to add a one-entry read tag that skips repeated reads.
module memc_sram
  import memc_pkg::*;
#(
  parameter int T_RD  = 5,
  parameter int T_WR  = 5,
  parameter int T_REC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MEMC_AW-1:0] mem_addr,
  input  logic [MEMC_DW-1:0] mem_dati,
  input  logic               mem_oe,
  input  logic               mem_we_lo,
  input  logic               mem_we_hi,
  output logic [MEMC_DW-1:0] mem_dato,
  output logic               mem_busy,
  output logic [MEMC_AW-1:0] ram_addr,
  input  logic [MEMC_DW-1:0] ram_dq_i,
  output logic [MEMC_DW-1:0] ram_dq_o,
  output logic               ram_dq_oe,
  output logic               ram_ce_n,
  output logic               ram_oe_n,
  output logic               ram_we_n,
  output logic               ram_lb_n,
  output logic               ram_ub_n
);

  localparam logic [3:0] RD_LOAD  = wait_load(T_RD);
  localparam logic [3:0] WR_LOAD  = wait_load(T_WR);
  localparam logic [3:0] REC_LOAD = wait_load(T_REC);

  memc_state_e state_r;
  logic [3:0]  cnt_r;
  logic        cur_wr_r;
  logic        cur_lo_r;
  logic        cur_hi_r;
  memc_slot_t  req_s;
  logic        req_wr_s;
  logic        wr_trig_s;
  logic        rd_hit_s;
  logic        take_s;
  logic        rd_done_s;

  memc_req u_req (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_dati (mem_dati),
    .mem_oe   (mem_oe),
    .mem_we_lo(mem_we_lo),
    .mem_we_hi(mem_we_hi),
    .rd_hit   (rd_hit_s),
    .take     (take_s),
    .wr_trig  (wr_trig_s),
    .req      (req_s),
    .req_wr   (req_wr_s)
  );

  // A new access may start from IDLE or straight out of the last REC clock
  always_comb begin
    take_s    = req_s.valid && ((state_r == ST_IDLE) ||
                                ((state_r == ST_REC) && (cnt_r == 4'd0)));
    rd_done_s = (state_r == ST_RD) && (cnt_r == 4'd0);
  end

`ifdef MEMC_RDCACHE_EN
  logic [MEMC_AW-1:0] tag_r;
  logic               tag_valid_r;

  // A write trigger on the same edge must not be overtaken by a hit
  always_comb begin
    rd_hit_s = tag_valid_r && (tag_r == mem_addr) && !wr_trig_s;
  end

  // Tag follows the last completed read; any write invalidates it
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_r       <= '0;
      tag_valid_r <= 1'b0;
    end else if (wr_trig_s) begin
      tag_valid_r <= 1'b0;
    end else if (rd_done_s) begin
      tag_r       <= ram_addr;
      tag_valid_r <= 1'b1;
    end
  end
`else
  // Every read trigger goes to the chip
  always_comb begin
    rd_hit_s = 1'b0;
  end
`endif

  // Access state machine with registered chip strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      cur_wr_r  <= 1'b0;
      cur_lo_r  <= 1'b0;
      cur_hi_r  <= 1'b0;
      mem_dato  <= '0;
      mem_busy  <= 1'b0;
      ram_addr  <= '0;
      ram_dq_o  <= '0;
      ram_dq_oe <= 1'b0;
      ram_ce_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_lb_n  <= 1'b1;
      ram_ub_n  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_REC: begin
          // Write data is held through the first REC clock only
          ram_dq_oe <= 1'b0;
          if (take_s) begin
            state_r   <= ST_SETUP;
            mem_busy  <= 1'b1;
            ram_addr  <= req_s.addr;
            ram_ce_n  <= 1'b0;
            ram_dq_oe <= req_wr_s;
            cur_wr_r  <= req_wr_s;
            cur_lo_r  <= req_s.be_lo;
            cur_hi_r  <= req_s.be_hi;
            if (req_wr_s) begin
              ram_dq_o <= req_s.data;
            end
          end else if ((state_r == ST_REC) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r  <= ST_IDLE;
            mem_busy <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cur_wr_r) begin
            state_r  <= ST_WR;
            cnt_r    <= WR_LOAD;
            ram_we_n <= 1'b0;
            ram_lb_n <= !cur_lo_r;
            ram_ub_n <= !cur_hi_r;
          end else begin
            state_r  <= ST_RD;
            cnt_r    <= RD_LOAD;
            ram_oe_n <= 1'b0;
            ram_lb_n <= 1'b0;
            ram_ub_n <= 1'b0;
          end
        end
        ST_RD: begin
          if (cnt_r == 4'd0) begin
            state_r  <= ST_REC;
            cnt_r    <= REC_LOAD;
            mem_dato <= ram_dq_i;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_lb_n <= 1'b1;
            ram_ub_n <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_WR: begin
          if (cnt_r == 4'd0) begin
            state_r  <= ST_REC;
            cnt_r    <= REC_LOAD;
            ram_ce_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_lb_n <= 1'b1;
            ram_ub_n <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_busy  <= 1'b0;
          ram_dq_oe <= 1'b0;
          ram_ce_n  <= 1'b1;
          ram_oe_n  <= 1'b1;
          ram_we_n  <= 1'b1;
          ram_lb_n  <= 1'b1;
          ram_ub_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule
